// File: rtl/elc3_mmio_pkg.sv
// elc3_mmio_pkg: eLC-3 MMIO register addresses, status bit positions and register decode.
package elc3_mmio_pkg;
  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR = 16'hFE04;
  localparam logic [15:0] ADDR_DDR = 16'hFE06;
  localparam int SR_READY_BIT = 15;
  localparam int SR_IE_BIT = 14;
  typedef enum logic [2:0] {IO_NONE, IO_KBSR, IO_KBDR, IO_DSR, IO_DDR} io_reg_e;
  function automatic io_reg_e decode(input logic [15:0] a);
    return a == ADDR_KBSR ? IO_KBSR :
           a == ADDR_KBDR ? IO_KBDR :
           a == ADDR_DSR ? IO_DSR :
           a == ADDR_DDR ? IO_DDR : IO_NONE;
  endfunction
endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous byte FIFO for keyboard input; push ignored when full, pop ignored when empty.
module kbd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/mmio_device_regs.sv
// mmio_device_regs: eLC-3 MMIO responder for KBSR/KBDR/DSR/DDR with keyboard FIFO and video handshake.
// Optional keyboard interrupt (IE bit and Kbd_IRQ) enabled by defining MMIO_KBD_IRQ_EN.
module mmio_device_regs
  import elc3_mmio_pkg::*;
#(
  parameter int KBD_FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] Address,
  input  logic [15:0] Data_FromCPU,
  output logic [15:0] Data_ToCPU,
  output logic        IO_Hit,
  input  logic        Kbd_Valid,
  input  logic [7:0]  Kbd_Data,
  output logic        Kbd_Ready,
  output logic        Video_Valid,
  output logic [15:0] Video_Data,
  input  logic        Video_Ready,
  output logic        Kbd_IRQ
);
  io_reg_e sel;
  logic mio_q, start, full, empty, pop, wr_start, ie;
  logic [7:0] head;
  logic [15:0] rd_data;
  assign sel = MIO_EN ? decode(Address) : IO_NONE;
  assign IO_Hit = sel != IO_NONE;
  assign start = MIO_EN & ~mio_q;
  assign wr_start = start & ~R_W;
  assign pop = start & R_W & (sel == IO_KBDR) & ~empty;
  assign Kbd_Ready = ~full;
  kbd_fifo #(.DEPTH(KBD_FIFO_DEPTH)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .push(Kbd_Valid),
    .pop(pop),
    .din(Kbd_Data),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // KBDR keeps its start-cycle value for the rest of the access, since head moves after the pop.
  always_comb
    rd_data = sel == IO_KBSR ? {~empty, ie, 14'b0} :
              sel == IO_KBDR ? (start ? (empty ? 16'h0000 : {8'h00, head}) : Data_ToCPU) :
              sel == IO_DSR ? {~Video_Valid, 15'b0} : 16'h0000;
  // mio_q resets high so an access already in flight when reset drops is not seen as a new start.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      mio_q <= 1'b1;
      Data_ToCPU <= '0;
      Video_Valid <= 1'b0;
      Video_Data <= '0;
    end else begin
      mio_q <= MIO_EN;
      if (IO_Hit && R_W) Data_ToCPU <= rd_data;
      if (wr_start && sel == IO_DDR && !Video_Valid) begin
        Video_Data <= Data_FromCPU;
        Video_Valid <= 1'b1;
      end else if (Video_Valid && Video_Ready) Video_Valid <= 1'b0;
    end
`ifdef MMIO_KBD_IRQ_EN
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      ie <= 1'b0;
      Kbd_IRQ <= 1'b0;
    end else begin
      if (wr_start && sel == IO_KBSR) ie <= Data_FromCPU[SR_IE_BIT];
      Kbd_IRQ <= ie & ~empty;
    end
`else
  assign ie = 1'b0;
  assign Kbd_IRQ = 1'b0;
`endif
endmodule
